shift_sequencer: RTL and testbench



---
 rtl/alu_shift_pkg.sv | 23 ++
 rtl/shift_step_1b.sv | 49 ++++
 rtl/shift_sequencer.sv | 130 +++++++++++++
 tb/tb_shift_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU shift datapath.
//   sh_mode_t   : shift mode encodings (logical, arithmetic, rotate, external fill)
//   SH_LEFT/SH_RIGHT : direction constants, matching the single-step shift stage
//   seq_state_t : sequencer FSM state encodings
package alu_shift_pkg;

  typedef enum logic [1:0] {
    SH_LOGIC = 2'b00,
    SH_ARITH = 2'b01,
    SH_ROT   = 2'b10,
    SH_EXT   = 2'b11
  } sh_mode_t;

  localparam logic SH_LEFT  = 1'b0;
  localparam logic SH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_step_1b.sv
// Combinational single-step (1-bit) shifter.
// Ports:
//   data      : word to shift
//   dir       : SH_LEFT (toward MSB) or SH_RIGHT (toward LSB)
//   mode      : logical / arithmetic / rotate / external fill
//   fill      : bit inserted in external-fill mode
//   next_data : word after one step
//   bit_out   : bit that left the word (old MSB on left, old LSB on right)
module shift_step_1b
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  sh_mode_t         mode,
  input  logic             fill,
  output logic [WIDTH-1:0] next_data,
  output logic             bit_out
);

  logic in_bit;

  always_comb begin
    in_bit    = 1'b0;
    next_data = data;
    bit_out   = 1'b0;
    if (dir == SH_LEFT) begin
      // Arithmetic left is identical to logical left: zero enters the LSB.
      case (mode)
        SH_ROT:  in_bit = data[WIDTH-1];
        SH_EXT:  in_bit = fill;
        default: in_bit = 1'b0;
      endcase
      next_data = {data[WIDTH-2:0], in_bit};
      bit_out   = data[WIDTH-1];
    end else begin
      case (mode)
        SH_ARITH: in_bit = data[WIDTH-1];
        SH_ROT:   in_bit = data[0];
        SH_EXT:   in_bit = fill;
        default:  in_bit = 1'b0;
      endcase
      next_data = {in_bit, data[WIDTH-1:1]};
      bit_out   = data[0];
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Sequential multi-bit shifter: accepts one request over a valid/ready
// handshake, applies one 1-bit step per clock, and returns the shifted word
// and the last bit shifted out over a second valid/ready handshake.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : request handshake (in_ready high only in IDLE)
//   in_data, in_dir, in_mode, in_amount, in_fill : request fields, sampled at acceptance
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   out_data, out_carry  : result word and last bit shifted out (0 when amount = 0)
//   busy                 : high while in SHIFT or DONE
module shift_sequencer
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_fill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             busy
);

  seq_state_t       state;
  logic [WIDTH-1:0] data_q;
  logic             carry_q;
  logic [AMT_W-1:0] count_q;
  logic             dir_q;
  sh_mode_t         mode_q;
  logic             fill_q;

  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] step_data;
  logic             step_bit;

  shift_step_1b #(
    .WIDTH(WIDTH)
  ) u_step (
    .data      (data_q),
    .dir       (dir_q),
    .mode      (mode_q),
    .fill      (fill_q),
    .next_data (step_data),
    .bit_out   (step_bit)
  );

  // Handshake/status flags are registered together with the state so that
  // no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      data_q      <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      dir_q       <= SH_LEFT;
      mode_q      <= SH_LOGIC;
      fill_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            dir_q      <= in_dir;
            mode_q     <= sh_mode_t'(in_mode);
            fill_q     <= in_fill;
            count_q    <= in_amount;
            carry_q    <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            // A zero amount skips straight to DONE with the word untouched.
            if (in_amount != '0) begin
              state <= ST_SHIFT;
            end else begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          data_q  <= step_data;
          carry_q <= step_bit;
          count_q <= count_q - AMT_W'(1);
          if (count_q == AMT_W'(1)) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = data_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: reset state, a table of directed vectors,
// backpressure and mid-operation reset sequences, then randomized
// back-to-back requests compared against a behavioural model.
module tb_shift_sequencer;

  localparam int WIDTH = 4;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_dir = 1'b0;
  logic [1:0]       in_mode = 2'b00;
  logic [AMT_W-1:0] in_amount = '0;
  logic             in_fill = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .in_amount (in_amount),
    .in_fill   (in_fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             dir;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amt;
    logic             fill;
    logic [WIDTH-1:0] exp_data;
    logic             exp_carry;
  } vec_t;

  vec_t vecs[11];

  // Result capture for the random phase.
  bit        mon_en = 1'b0;
  int        hs_count = 0;
  logic [WIDTH:0] got_q[$];
  logic [WIDTH:0] exp_q[$];

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      got_q.push_back({out_data, out_carry});
      hs_count++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: the word is treated as an integer; a left step
  // doubles it (dropping the top bit) and adds the entering bit, a right
  // step halves it and adds the entering bit weighted by the top position.
  task automatic ref_shift(input int data, input int dir, input int mode, input int amt,
                           input int fill, output int res, output int carry);
    int v, c, inb;
    int top, span;
    top  = 1 << (WIDTH - 1);
    span = 1 << WIDTH;
    v = data;
    c = 0;
    for (int k = 0; k < amt; k++) begin
      if (dir == 0) begin
        c = (v >= top) ? 1 : 0;
        inb = (mode == 2) ? c : (mode == 3) ? fill : 0;
        v = (v * 2) % span + inb;
      end else begin
        c = v % 2;
        inb = (mode == 0) ? 0 : (mode == 1) ? ((v >= top) ? 1 : 0) : (mode == 2) ? c : fill;
        v = v / 2 + inb * top;
      end
    end
    res = v;
    carry = c;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: in_ready timeout, got 0, expected 1", name);
    end
  endtask

  task automatic run_vec(input int idx);
    int n;
    in_data   = vecs[idx].data;
    in_dir    = vecs[idx].dir;
    in_mode   = vecs[idx].mode;
    in_amount = vecs[idx].amt;
    in_fill   = vecs[idx].fill;
    in_valid  = 1'b1;
    wait_ready($sformatf("vec%0d", idx));
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = ~vecs[idx].data;
    in_fill = ~vecs[idx].fill;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check($sformatf("vec%0d_latency", idx), n, vecs[idx].amt + 1);
    check($sformatf("vec%0d_data", idx), out_data, vecs[idx].exp_data);
    check($sformatf("vec%0d_carry", idx), out_carry, vecs[idx].exp_carry);
  endtask

  initial begin
    int prev_acc, acc, prev_amt, n, r, c;
    bit stale;

    //                data     dir  mode   amt    fill  exp      carry
    vecs[0]  = '{4'b1011, 1'b0, 2'b00, 3'd2, 1'b0, 4'b1100, 1'b0};
    vecs[1]  = '{4'b1010, 1'b1, 2'b01, 3'd3, 1'b0, 4'b1111, 1'b0};
    vecs[2]  = '{4'b0011, 1'b1, 2'b10, 3'd1, 1'b0, 4'b1001, 1'b1};
    vecs[3]  = '{4'b0000, 1'b0, 2'b11, 3'd2, 1'b1, 4'b0011, 1'b0};
    vecs[4]  = '{4'b0110, 1'b0, 2'b00, 3'd0, 1'b0, 4'b0110, 1'b0};
    vecs[5]  = '{4'b0001, 1'b0, 2'b00, 3'd4, 1'b0, 4'b0000, 1'b1};
    vecs[6]  = '{4'b0001, 1'b0, 2'b00, 3'd7, 1'b0, 4'b0000, 1'b0};
    vecs[7]  = '{4'b1001, 1'b0, 2'b10, 3'd5, 1'b0, 4'b0011, 1'b1};
    vecs[8]  = '{4'b1000, 1'b1, 2'b00, 3'd3, 1'b0, 4'b0001, 1'b0};
    vecs[9]  = '{4'b0000, 1'b1, 2'b11, 3'd7, 1'b1, 4'b1111, 1'b1};
    vecs[10] = '{4'b0111, 1'b1, 2'b01, 3'd2, 1'b0, 4'b0001, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_carry", out_carry, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) run_vec(i);
    @(negedge clk);

    // Backpressure: rotate left 1101 by 1 -> 1011, carry 1
    out_ready = 1'b0;
    in_data = 4'b1101; in_dir = 1'b0; in_mode = 2'b10; in_amount = 3'd1; in_fill = 1'b0;
    in_valid = 1'b1;
    wait_ready("bp");
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check("bp_valid", out_valid, 1);
    in_data = 4'b1111; in_amount = 3'd0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_data%0d", k), out_data, 4'b1011);
      check($sformatf("bp_hold_carry%0d", k), out_carry, 1);
      check($sformatf("bp_hold_ready%0d", k), in_ready, 0);
      check($sformatf("bp_hold_valid%0d", k), out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_busy", busy, 0);
    @(negedge clk);
    check("bp_no_accept_valid", out_valid, 0);
    check("bp_no_accept_data", out_data, 4'b1011);

    // Reset in the middle of a 5-step logical left shift of 1111
    in_data = 4'b1111; in_dir = 1'b0; in_mode = 2'b00; in_amount = 3'd5; in_fill = 1'b0;
    in_valid = 1'b1;
    wait_ready("rst_mid");
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_out_data", out_data, 0);
    check("rstmid_out_carry", out_carry, 0);
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("rstmid_stale_valid", stale, 0);
    check("rstmid_ready_after", in_ready, 1);

    // Randomized back-to-back requests with in_valid held high
    mon_en = 1'b1;
    got_q.delete();
    exp_q.delete();
    prev_acc = 0;
    prev_amt = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_data   = WIDTH'($urandom_range((1 << WIDTH) - 1));
      in_dir    = 1'($urandom_range(1));
      in_mode   = 2'($urandom_range(3));
      in_amount = AMT_W'($urandom_range((1 << AMT_W) - 1));
      in_fill   = 1'($urandom_range(1));
      wait_ready($sformatf("rnd%0d", i));
      acc = cyc + 1;
      if (i > 0) check($sformatf("rnd%0d_spacing", i), acc - prev_acc, prev_amt + 2);
      ref_shift(int'(in_data), int'(in_dir), int'(in_mode), int'(in_amount), int'(in_fill), r, c);
      exp_q.push_back({WIDTH'(r), 1'(c)});
      prev_acc = acc;
      prev_amt = int'(in_amount);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    while (hs_count < 200 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("rnd_handshakes", hs_count, 200);
    check("rnd_results", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("rnd%0d_result", i), got_q[i], exp_q[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
